// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register, IF/ID pipeline register,
// RUN/HALT break control and a count of fetched instructions.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   PCWrite             PC update enable (hazard unit)
//   IF_ID_Write         IF/ID load enable (hazard unit)
//   IF_ID_FLUSH         IF/ID clear-to-NOP (hazard unit)
//   PCSrc, branch_target taken branch/jump and its redirect address
//   brk, resume         enter / leave HALT
//   instr_in            instruction memory read data for address pc
//   pc                  current fetch address
//   IF_ID_PC4, IF_ID_INSTR, IF_ID_RS, IF_ID_RT  IF/ID register contents
//   halted              high while in HALT
//   fetch_count         instructions accepted into IF/ID (wraps)
module if_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCWrite,
   input  logic        IF_ID_Write,
   input  logic        IF_ID_FLUSH,
   input  logic        PCSrc,
   input  logic [31:0] branch_target,
   input  logic        brk,
   input  logic        resume,
   input  logic [31:0] instr_in,
   output logic [31:0] pc,
   output logic [31:0] IF_ID_PC4,
   output logic [31:0] IF_ID_INSTR,
   output logic [4:0]  IF_ID_RS,
   output logic [4:0]  IF_ID_RT,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = '0;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target_aligned;

   // Sequential fetch address wraps naturally modulo 2^32.
   assign pc_plus4       = pc + XLEN'(4);
   // Redirect targets are forced to word alignment.
   assign target_aligned = branch_target & ~XLEN'(3);

   // Register slices of the latched instruction.
   assign IF_ID_RS = IF_ID_INSTR[25:21];
   assign IF_ID_RT = IF_ID_INSTR[20:16];

   // State machine, PC, IF/ID register and fetch counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RUN;
         halted      <= 1'b0;
         pc          <= '0;
         IF_ID_PC4   <= '0;
         IF_ID_INSTR <= NOP;
         fetch_count <= '0;
      end else if (state == S_RUN) begin
         if (brk) begin
            // Entering HALT: freeze pc and drain IF/ID to a bubble.
            state       <= S_HALT;
            halted      <= 1'b1;
            IF_ID_PC4   <= '0;
            IF_ID_INSTR <= NOP;
         end else begin
            if (PCWrite) begin
               pc <= PCSrc ? target_aligned : pc_plus4;
            end
            if (IF_ID_FLUSH) begin
               IF_ID_PC4   <= '0;
               IF_ID_INSTR <= NOP;
            end else if (IF_ID_Write) begin
               IF_ID_PC4   <= pc_plus4;
               IF_ID_INSTR <= instr_in;
               fetch_count <= fetch_count + XLEN'(1);
            end
         end
      end else begin
         // HALT: hazard controls ignored, bubbles fed every cycle.
         IF_ID_PC4   <= '0;
         IF_ID_INSTR <= NOP;
         if (resume && !brk) begin
            state  <= S_RUN;
            halted <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCWrite, IF_ID_Write, IF_ID_FLUSH, PCSrc, brk, resume;
   logic [31:0] branch_target, instr_in;
   logic [31:0] pc, IF_ID_PC4, IF_ID_INSTR, fetch_count;
   logic [4:0]  IF_ID_RS, IF_ID_RT;
   logic        halted;

   if_stage dut (
      .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .IF_ID_FLUSH(IF_ID_FLUSH), .PCSrc(PCSrc), .branch_target(branch_target),
      .brk(brk), .resume(resume), .instr_in(instr_in), .pc(pc),
      .IF_ID_PC4(IF_ID_PC4), .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_RS(IF_ID_RS),
      .IF_ID_RT(IF_ID_RT), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic [31:0] cnt;
      logic        halted;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic fixed_mode = 1'b1;
   localparam logic [31:0] FIXED_INSTR = 32'h2008_0001;

   // Reference model state
   logic [31:0] m_pc, m_pc4, m_instr, m_cnt;
   logic        m_halt;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return fixed_mode ? FIXED_INSTR : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
   endfunction

   // Instruction memory: combinational read at the DUT's fetch address.
   always_comb instr_in = imem(pc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_cnt = 0; m_halt = 1'b0;
   endtask

   task automatic idle_inputs();
      PCWrite = 0; IF_ID_Write = 0; IF_ID_FLUSH = 0; PCSrc = 0;
      branch_target = 0; brk = 0; resume = 0;
   endtask

   // Apply one cycle of controls and queue the expected post-edge state.
   task automatic step(input logic pcw, input logic ifw, input logic fl, input logic src,
                       input logic [31:0] tgt, input logic b, input logic r);
      exp_t e;
      logic [31:0] fetched;
      @(negedge clk);
      PCWrite = pcw; IF_ID_Write = ifw; IF_ID_FLUSH = fl; PCSrc = src;
      branch_target = tgt; brk = b; resume = r;
      fetched = imem(m_pc);
      if (m_halt) begin
         m_instr = 0; m_pc4 = 0;
         if (r && !b) m_halt = 1'b0;
      end else if (b) begin
         m_halt = 1'b1; m_instr = 0; m_pc4 = 0;
      end else begin
         if (fl) begin
            m_instr = 0; m_pc4 = 0;
         end else if (ifw) begin
            m_instr = fetched; m_pc4 = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
         end
         if (pcw) m_pc = src ? (tgt / 4) * 4 : m_pc + 32'd4;
      end
      e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.cnt = m_cnt; e.halted = m_halt;
      q.push_back(e);
   endtask

   task automatic drain();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare DUT against the oldest expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_pc4", IF_ID_PC4, e.pc4);
            chk("sb_instr", IF_ID_INSTR, e.instr);
            chk("sb_rs", 32'(IF_ID_RS), 32'(e.instr[25:21]));
            chk("sb_rt", 32'(IF_ID_RT), 32'(e.instr[20:16]));
            chk("sb_cnt", fetch_count, e.cnt);
            chk("sb_halted", 32'(halted), 32'(e.halted));
         end
      end
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #3;
      chk("rst_pc", pc, 0);
      chk("rst_instr", IF_ID_INSTR, 0);
      chk("rst_halted", 32'(halted), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch, one-cycle stall at 0x8, then continue.
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      drain();
      chk("seq_pc8", pc, 32'h8);
      step(0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("stall_pc", pc, 32'h8);
      chk("stall_instr", IF_ID_INSTR, FIXED_INSTR);
      chk("stall_cnt", fetch_count, 2);
      step(1, 1, 0, 0, 0, 0, 0);
      drain();
      chk("seq_pc", pc, 32'hC);
      chk("seq_pc4", IF_ID_PC4, 32'hC);
      chk("seq_cnt", fetch_count, 3);

      // Taken branch with flush; unaligned target bits dropped.
      step(1, 0, 1, 1, 32'h43, 0, 0);
      drain();
      chk("br_pc", pc, 32'h40);
      chk("br_instr", IF_ID_INSTR, 0);
      chk("br_rs", 32'(IF_ID_RS), 0);

      // Break at 0x10, HALT ignores hazard controls, resume.
      fixed_mode = 1'b0;
      step(1, 0, 1, 1, 32'h10, 0, 0);
      step(1, 1, 0, 1, 32'h80, 1, 0);
      for (int i = 0; i < 5; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0, 0);
      drain();
      chk("halt_pc", pc, 32'h10);
      chk("halt_instr", IF_ID_INSTR, 0);
      chk("halt_flag", 32'(halted), 1);
      step(1, 1, 0, 1, 32'h80, 0, 1);
      drain();
      chk("resume_pc", pc, 32'h10);
      chk("resume_flag", 32'(halted), 0);
      step(1, 1, 0, 0, 0, 0, 0);
      drain();
      chk("resume_pc4", IF_ID_PC4, 32'h14);
      chk("resume_instr", IF_ID_INSTR, imem(32'h10));

      // PC wrap.
      step(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      drain();
      chk("wrap_pc", pc, 0);
      chk("wrap_pc4", IF_ID_PC4, 0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
              $urandom, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));

      // Async reset while halted at 0x24.
      step(1, 0, 1, 1, 32'h24, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("pre_rst_pc", pc, 32'h24);
      chk("pre_rst_halted", 32'(halted), 1);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 0);
      chk("arst_pc4", IF_ID_PC4, 0);
      chk("arst_instr", IF_ID_INSTR, 0);
      chk("arst_cnt", fetch_count, 0);
      chk("arst_halted", 32'(halted), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1, 1, 0, 0, 0, 0, 0);
      drain();
      chk("post_rst_pc4", IF_ID_PC4, 32'h4);
      chk("post_rst_instr", IF_ID_INSTR, imem(32'h0));
      chk("queue_drain", 32'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port PCWrite  input  1  PC update enable from hazard unit.
REQ-004 SHALL have port IF_ID_Write  input  1  IF/ID register load enable from hazard unit.
REQ-005 SHALL have port IF_ID_FLUSH  input  1  IF/ID register clear-to-NOP from hazard unit.
REQ-006 SHALL have port PCSrc  input  1  branch/jump taken.
REQ-007 SHALL have port branch_target  input  32  redirect address.
REQ-008 SHALL have port brk  input  1  break request; enters HALT.
REQ-009 SHALL have port resume  input  1  leave HALT.
REQ-010 SHALL have port instr_in  input  32  instruction memory read data for address pc (combinational read).
REQ-011 SHALL have port pc  output  32  current fetch address to instruction memory.
REQ-012 SHALL have port IF_ID_PC4  output  32  registered pc+4 of instruction in IF/ID.
REQ-013 SHALL have port IF_ID_INSTR  output  32  registered instruction in IF/ID.
REQ-014 SHALL have port IF_ID_RS  output  5  IF_ID_INSTR[25:21].
REQ-015 SHALL have port IF_ID_RT  output  5  IF_ID_INSTR[20:16].
REQ-016 SHALL have port halted  output  1  high while in HALT.
REQ-017 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-018 SHALL implement state machine RUN/HALT; RUN->HALT on brk=1 at clock edge; HALT->RUN on resume=1 and brk=0; otherwise hold.
REQ-019 In RUN with PCWrite=1, pc SHALL load {branch_target[31:2],2'b00} if PCSrc=1, else pc+4.
REQ-020 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 In RUN with PCWrite=0, pc SHALL hold, independent of PCSrc.
REQ-022 IF/ID update priority SHALL be: FLUSH (instr<=0x00000000, pc4<=0) > Write (instr<=instr_in, pc4<=pc+4) > hold.
REQ-023 IF_ID_FLUSH=1 with IF_ID_Write=0 SHALL still clear IF/ID.
REQ-024 On the RUN->HALT edge, pc SHALL hold and IF/ID SHALL clear to NOP regardless of PCWrite/IF_ID_Write.
REQ-025 In HALT, pc SHALL hold, IF/ID SHALL load NOP every cycle, and PCWrite/PCSrc/IF_ID_Write SHALL be ignored.
REQ-026 On HALT->RUN edge, no fetch SHALL occur; normal fetch SHALL resume from held pc on the following edge.
REQ-027 fetch_count SHALL increment by 1 on each edge where IF/ID loads instr_in (Write=1, FLUSH=0, state RUN, brk=0); wraps modulo 2^32.
REQ-028 halted SHALL be a registered output equal to (state==HALT).
REQ-029 IF_ID_RS/IF_ID_RT SHALL be pure slices of IF_ID_INSTR, no extra latency.
REQ-030 Fetch latency SHALL be one cycle: instr_in at pc on edge N appears on IF_ID_INSTR after edge N.

Reset
REQ-031 rst_n=0 SHALL immediately, without clock, set pc=0, IF_ID_INSTR=0, IF_ID_PC4=0, fetch_count=0, state=RUN, halted=0.
REQ-032 Reset asserted mid-HALT or mid-stall SHALL discard that state; first fetch after rst_n rises SHALL be from address 0 at the first rising edge.

Verification
REQ-033 Sequential fetch: reset, PCWrite=IF_ID_Write=1, instr_in=0x20080001 -> after 3 edges pc=0xC, IF_ID_PC4=0xC, IF_ID_INSTR=0x20080001, fetch_count=3.
REQ-034 Load-use stall: PCWrite=IF_ID_Write=0 for 1 cycle at pc=0x8 -> pc stays 0x8, IF_ID_INSTR unchanged, fetch_count unchanged.
REQ-035 Taken branch: PCSrc=1, branch_target=0x40, IF_ID_FLUSH=1, IF_ID_Write=0, PCWrite=1 -> next edge pc=0x40, IF_ID_INSTR=0, IF_ID_RS=0, IF_ID_RT=0.
REQ-036 Break/resume: brk=1 one cycle at pc=0x10 -> halted=1, pc=0x10 held for 5 cycles with IF_ID_INSTR=0; resume=1 -> halted=0, next fetch from 0x10.
REQ-037 Wrap: force pc to 0xFFFFFFFC, PCWrite=1 -> pc=0x00000000, IF_ID_PC4=0x00000000.
REQ-038 Async reset: drop rst_n between edges while halted at pc=0x24 -> outputs zero and halted=0 before next edge.
